dct_coeff_sequencer: RTL



---
 rtl/dct_pkg.sv | 47 ++++
 rtl/dct_mac_pipe.sv | 54 +++++
 rtl/dct_coeff_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared types, constants and the output rounding helper for the
// 8x8 DCT coefficient sequencer.
//   idx3_t     - 3-bit row/column/frequency index
//   coef_t     - default-width signed output coefficient
//   state_t    - sequencer FSM states
//   round_sat  - round-half-up arithmetic right shift, then clamp to a
//                signed range of the requested width
package dct_pkg;

    localparam int FRAC_BITS = 10;
    localparam int BLOCK_N   = 8;
    localparam int BLOCK_PIX = BLOCK_N * BLOCK_N;

    typedef logic [2:0]         idx3_t;
    typedef logic signed [11:0] coef_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } state_t;

    // Adds half an LSB of the output before the arithmetic shift so the
    // result rounds to nearest, then clamps into [-2^(cw-1), 2^(cw-1)-1].
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 cw
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = acc;
        if (frac > 0)
            v = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (cw - 1));
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: level shift, registered multiply and accumulator for one
// DCT coefficient.
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_clr          - clear the accumulator (start of a coefficient)
//   i_issue        - a pixel address was issued this cycle
//   i_pix          - pixel data, valid one cycle after the issue
//   i_cos          - signed cosine term aligned with i_pix
//   o_acc          - signed running sum of pixel * cosine products
module dct_mac_pipe #(
    parameter int PIX_W       = 8,
    parameter int COS_W       = 32,
    parameter int ACC_W       = 32,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_issue,
    input  logic [PIX_W-1:0] i_pix,
    input  logic [COS_W-1:0] i_cos,
    output logic [ACC_W-1:0] o_acc
);

    localparam int PROD_W = PIX_W + 1 + COS_W;
    localparam int LS_INT = (LEVEL_SHIFT != 0) ? (1 << (PIX_W - 1)) : 0;
    localparam logic signed [PIX_W:0] LS_OFF = LS_INT[PIX_W:0];

    // [1]: pixel data on i_pix is live; [2]: r_prod holds a live product
    logic [2:1]              r_vld_pipe;
    logic signed [PIX_W:0]   w_op;
    logic signed [ACC_W-1:0] r_prod;
    logic signed [ACC_W-1:0] r_acc;

    assign w_op = $signed({1'b0, i_pix}) - LS_OFF;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_pipe <= '0;
            r_prod     <= '0;
            r_acc      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], i_issue};
            // Full-width signed product, then fit to the accumulator width
            r_prod <= ACC_W'(PROD_W'(w_op) * PROD_W'($signed(i_cos)));
            if (i_clr)
                r_acc <= '0;
            else if (r_vld_pipe[2])
                r_acc <= r_acc + r_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dct_coeff_sequencer.sv
// dct_coeff_sequencer: walks every (k1,k2) of an 8x8 block in row-major
// order, streams all 64 pixels through the cosine LUT bank and one MAC,
// and hands out one rounded, saturated coefficient per (k1,k2).
//   i_clk, i_reset            - clock, synchronous active-high reset
//   i_start / o_busy / o_done - block start (IDLE only), activity, end pulse
//   o_pix_raddr, i_pix_rdata  - pixel buffer read {n1,n2}, data one cycle later
//   o_lut_k1/k2, o_lut_n1/n2  - LUT select and index aligned with i_pix_rdata
//   i_cos_term                - combinational LUT output
//   o_coef_valid/i_coef_ready - coefficient handshake
//   o_coef_data, o_coef_k1/k2 - coefficient and its frequency indices
module dct_coeff_sequencer #(
    parameter int K_MAX       = 8,
    parameter int PIX_W       = 8,
    parameter int COS_W       = 32,
    parameter int FRAC_BITS   = 10,
    parameter int ACC_W       = 32,
    parameter int COEF_W      = 12,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [5:0]        o_pix_raddr,
    input  logic [PIX_W-1:0]  i_pix_rdata,
    output logic [2:0]        o_lut_k1,
    output logic [2:0]        o_lut_k2,
    output logic [2:0]        o_lut_n1,
    output logic [2:0]        o_lut_n2,
    input  logic [COS_W-1:0]  i_cos_term,
    output logic              o_coef_valid,
    input  logic              i_coef_ready,
    output logic [COEF_W-1:0] o_coef_data,
    output logic [2:0]        o_coef_k1,
    output logic [2:0]        o_coef_k2
);
    import dct_pkg::*;

    localparam idx3_t      K_LAST   = idx3_t'(K_MAX - 1);
    localparam logic [5:0] PIX_LAST = 6'(BLOCK_PIX - 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_i;
    logic [5:0]       r_lut_n;
    logic [1:0]       r_drain;
    idx3_t            r_k1;
    idx3_t            r_k2;
    logic             w_clr;
    logic             w_issue;
    logic             w_hs;
    logic             w_last;
    logic [ACC_W-1:0] w_acc;

    assign w_last = (r_k1 == K_LAST) && (r_k2 == K_LAST);

    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_issue = 1'b0;
        w_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = RUN;
                    w_clr  = 1'b1;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_i == PIX_LAST)
                    w_next = DRAIN;
            end
            // Three cycles lets the last product reach the accumulator
            DRAIN: begin
                if (r_drain == 2'd2)
                    w_next = OUT;
            end
            OUT: begin
                if (i_coef_ready) begin
                    w_hs = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                        w_clr  = 1'b1;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_lut_n <= '0;
            r_drain <= '0;
            r_k1    <= '0;
            r_k2    <= '0;
        end else begin
            r_state <= w_next;
            // LUT index trails the address by one cycle, matching read latency
            r_lut_n <= r_i;
            if (w_clr)
                r_i <= '0;
            else if (w_issue)
                r_i <= r_i + 6'd1;
            r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
            if (r_state == IDLE && i_start) begin
                r_k1 <= '0;
                r_k2 <= '0;
            end else if (w_hs && !w_last) begin
                if (r_k2 == K_LAST) begin
                    r_k2 <= '0;
                    r_k1 <= r_k1 + 3'd1;
                end else begin
                    r_k2 <= r_k2 + 3'd1;
                end
            end
        end
    end

    dct_mac_pipe #(
        .PIX_W      (PIX_W),
        .COS_W      (COS_W),
        .ACC_W      (ACC_W),
        .LEVEL_SHIFT(LEVEL_SHIFT)
    ) u_mac (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (w_clr),
        .i_issue(w_issue),
        .i_pix  (i_pix_rdata),
        .i_cos  (i_cos_term),
        .o_acc  (w_acc)
    );

    assign o_busy       = (r_state != IDLE);
    assign o_done       = (r_state == DONE);
    assign o_coef_valid = (r_state == OUT);
    assign o_pix_raddr  = r_i;
    assign o_lut_k1     = r_k1;
    assign o_lut_k2     = r_k2;
    assign o_lut_n1     = r_lut_n[5:3];
    assign o_lut_n2     = r_lut_n[2:0];
    assign o_coef_k1    = r_k1;
    assign o_coef_k2    = r_k2;
    // Accumulator is frozen outside RUN/DRAIN, so this holds during a stall
    assign o_coef_data  = COEF_W'(round_sat(64'($signed(w_acc)), FRAC_BITS, COEF_W));

endmodule
